// File: rtl/gbuff_stream_reader_pkg.sv
// rtl/gbuff_stream_reader_pkg.sv - shared constants and FSM encoding for gbuff_stream_reader
//
// Purpose: word/address widths used as parameter defaults, skid buffer depth,
// and the reader FSM state encoding. No ports.
package gbuff_stream_reader_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int WORD_ADDR_BITS = 10;

    // Depth of the output skid buffer; also the read credit limit.
    localparam int SKID_DEPTH     = 2;
    localparam int SKID_CNT_W     = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gbuff_stream_reader_skid_fifo2.sv
// rtl/gbuff_stream_reader_skid_fifo2.sv - 2-entry synchronous skid FIFO with registered head
//
// Purpose: absorbs words returned by the SRAM while the downstream stalls.
// The head entry is a register, so valid_o/head_o depend only on state.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, din_i     write a word at the tail
//   pop_i             remove the head word (ignored when empty)
//   valid_o, head_o   head word present / head word
//   count_o           occupancy 0..2
module gbuff_stream_reader_skid_fifo2
    import gbuff_stream_reader_pkg::*;
#(
    parameter int W = WORD_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [W-1:0]          din_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [W-1:0]          head_o,
    output logic [SKID_CNT_W-1:0] count_o
);

    localparam logic [SKID_CNT_W-1:0] CNT_ONE  = SKID_CNT_W'(1);
    localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

    logic [W-1:0]          head_q, head_d;
    logic [W-1:0]          tail_q, tail_d;
    logic [SKID_CNT_W-1:0] count_q, count_d;
    logic                  do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, do_pop})
            2'b10: begin
                if (count_q == '0) begin
                    head_d = din_i;
                end else begin
                    tail_d = din_i;
                end
                // A push into a full FIFO is excluded by the upstream credit rule.
                if (count_q != CNT_FULL) begin
                    count_d = count_q + CNT_ONE;
                end
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CNT_ONE;
            end
            2'b11: begin
                // Occupancy stays the same; the new word either replaces the
                // head directly or queues behind the promoted tail.
                if (count_q == CNT_ONE) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/gbuff_stream_reader.sv
// rtl/gbuff_stream_reader.sv - streams n words from global buffer A as a valid/ready stream
//
// Purpose: start/done controlled read engine for a synchronous single-port
// SRAM with one-cycle read latency, feeding a 2-entry skid FIFO.
// Optional feature macro: GBUFF_STREAM_READER_LAST_EN (out_last marks word n-1;
// when undefined out_last is tied low and the FIFO stores data only).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start, n                      begin a transfer of n words (sampled in IDLE)
//   busy, done                    transfer in progress / one-cycle completion pulse
//   sram_wen, sram_addr, sram_do  SRAM port (read-only, registered address)
//   out_valid, out_data, out_last output stream
//   out_ready                     downstream accept
module gbuff_stream_reader
    import gbuff_stream_reader_pkg::*;
#(
    parameter int                DATA_W    = WORD_SIZE,
    parameter int                ADDR_W    = WORD_ADDR_BITS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n,
    output logic              busy,
    output logic              done,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_do,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last
);

`ifdef GBUFF_STREAM_READER_LAST_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0]   ADDR_ONE   = ADDR_W'(1);
    localparam logic [SKID_CNT_W:0] CREDIT_MAX = (SKID_CNT_W + 1)'(SKID_DEPTH);

    state_e                  state_q;
    logic [ADDR_W-1:0]       n_q;
    logic [ADDR_W-1:0]       rd_cnt_q;
    logic [ADDR_W-1:0]       tx_cnt_q;
    logic [ADDR_W-1:0]       sram_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rvalid_q;

    logic                    fifo_valid;
    logic [FIFO_W-1:0]       fifo_din;
    logic [FIFO_W-1:0]       fifo_head;
    logic [SKID_CNT_W-1:0]   fifo_count;

    logic                    hs;
    logic                    issue;
    logic                    rd_last;
    logic                    tx_last;
    logic [SKID_CNT_W:0]     credit_used;

    assign hs      = fifo_valid && out_ready;
    assign rd_last = (rd_cnt_q == n_q - ADDR_ONE);
    assign tx_last = (tx_cnt_q == n_q - ADDR_ONE);

    // The SRAM reads whatever sram_addr_q holds every cycle; a "read" is only
    // counted when issue is high, which also advances the address. Words
    // already in the FIFO, minus the one leaving this cycle, plus the one
    // coming back from the previous read, must leave a free slot; this keeps
    // one word per cycle while guaranteeing every returned word lands.
    assign credit_used = {{SKID_CNT_W{1'b0}}, rvalid_q}
                       + {1'b0, fifo_count}
                       - {{SKID_CNT_W{1'b0}}, hs};
    assign issue = (state_q == S_READ) && (credit_used < CREDIT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            rd_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            sram_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= issue;
            if (issue) begin
                sram_addr_q <= sram_addr_q + ADDR_ONE;
            end
            if (hs) begin
                tx_cnt_q <= tx_cnt_q + ADDR_ONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q         <= n;
                        rd_cnt_q    <= '0;
                        tx_cnt_q    <= '0;
                        sram_addr_q <= BASE_ADDR;
                        if (n == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + ADDR_ONE;
                        if (rd_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (hs && tx_last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GBUFF_STREAM_READER_LAST_EN
    // Last flag travels alongside the read it belongs to.
    logic last_pend_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pend_q <= 1'b0;
        end else begin
            last_pend_q <= issue && rd_last;
        end
    end

    assign fifo_din = {last_pend_q, sram_do};
    assign out_data = fifo_head[DATA_W-1:0];
    assign out_last = fifo_valid && fifo_head[DATA_W];
`else
    assign fifo_din = sram_do;
    assign out_data = fifo_head;
    assign out_last = 1'b0;
`endif

    gbuff_stream_reader_skid_fifo2 #(
        .W (FIFO_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (rvalid_q),
        .din_i   (fifo_din),
        .pop_i   (hs),
        .valid_o (fifo_valid),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_wen  = 1'b0;
    assign sram_addr = sram_addr_q;
    assign out_valid = fifo_valid;

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// tb/tb_gbuff_stream_reader.sv - scoreboard bench for gbuff_stream_reader
module tb_gbuff_stream_reader;

    localparam int                DATA_W = 16;
    localparam int                ADDR_W = 10;
    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE   = 10'd1020;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] n = '0;
    logic              busy;
    logic              done;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_do = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              out_last;

    logic [DATA_W-1:0] mem [DEPTH];
    exp_t              exp_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 0;
    int pidx = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int hs_count = 0;
    int last_hs = -1;
    int valid_cycles = 0;
    int first_valid = -1;
    int done_cnt = 0;
    bit stall_q = 1'b0;
    logic [DATA_W-1:0] held_data;
    logic              held_last;

    gbuff_stream_reader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .n         (n),
        .busy      (busy),
        .done      (done),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_do   (sram_do),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) sram_do <= mem[sram_addr];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = pat[pidx];
                    pidx = (pidx + 1) % 4;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", 32'(out_data), 32'(held_data));
                check_eq("stall_last", 32'(out_last), 32'(held_last));
            end
            stall_q   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                check_eq("fifo_le2", 32'(u_dut.u_fifo.count_o <= 2), 32'd1);
                check_eq("sram_wen", 32'(sram_wen), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got %0d expected no word", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("word_data", 32'(out_data), 32'(e.data));
                    check_eq("word_last", 32'(out_last), 32'(e.last));
                end
                hs_count++;
                last_hs = cyc;
            end
        end
    end

    task automatic push_expected(input int nw);
        exp_t e;
        for (int i = 0; i < nw; i++) begin
            e.data = mem[(int'(BASE) + i) % DEPTH];
`ifdef GBUFF_STREAM_READER_LAST_EN
            e.last = (i == nw - 1);
`else
            e.last = 1'b0;
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic run_xfer(input int nw, input int md, input bit mid);
        int  sc;
        int  dcyc;
        bit  seen;
        mode = md;
        push_expected(nw);
        hs_count = 0;
        valid_cycles = 0;
        first_valid = -1;
        done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        n = ADDR_W'(nw);
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = ADDR_W'($urandom);
        check_eq("busy_after_start", 32'(busy), 32'(nw != 0));
        seen = 1'b0;
        dcyc = 0;
        for (int k = 0; k < 30 * nw + 20 && !seen; k++) begin
            @(negedge clk);
            if (mid && k == 3) begin
                start = 1'b1;
                n = 10'd2;
            end else if (mid && k == 4) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("done_timing", 32'(dcyc), 32'((nw == 0) ? sc + 1 : last_hs + 1));
            check_eq("busy_at_done", 32'(busy), 32'd0);
            check_eq("word_count", 32'(hs_count), 32'(nw));
            check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
            if (nw == 0) begin
                check_eq("zero_len_valid", 32'(valid_cycles), 32'd0);
            end else if (md == 0) begin
                check_eq("first_latency", 32'(first_valid), 32'(sc + 3));
                check_eq("throughput", 32'(valid_cycles), 32'(nw));
            end
        end
        @(negedge clk);
        check_eq("done_pulse_low", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("done_once", 32'(done_cnt), 32'(seen));
        exp_q.delete();
    endtask

    task automatic reset_midway();
        bit reached;
        mode = 0;
        push_expected(10);
        hs_count = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        n = 10'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            @(negedge clk);
            #1;
            if (hs_count >= 3) reached = 1'b1;
        end
        check_eq("reset_reach_3", 32'(reached), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid_outputs",
                 {1'b0, busy, done, sram_wen, sram_addr, out_valid, out_data, out_last}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("reset_no_done", 32'(done_cnt), 32'd0);
        run_xfer(2, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 {1'b0, busy, done, sram_wen, sram_addr, out_valid, out_data, out_last}, 32'd0);
        rst_n = 1'b1;

        run_xfer(4, 0, 1'b0);
        run_xfer(8, 2, 1'b0);
        run_xfer(0, 0, 1'b0);
        run_xfer(8, 1, 1'b1);
        run_xfer(5, 1, 1'b0);
        reset_midway();
        for (int t = 0; t < 6; t++) begin
            int nw;
            nw = $urandom_range(1, 20);
            run_xfer(nw, $urandom_range(0, 2), nw >= 8);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
